// File: rtl/subsistema_despliegue_pkg.sv
// Shared types and constants for the display subsystem: FSM states, BCD digit type,
// active-low 7-segment codes (gfedcba) and the double-dabble add-3 step.
package paquete_despliegue;

    typedef enum logic [1:0] {
        ESPERA    = 2'd0,
        CONVIERTE = 2'd1,
        MUESTRA   = 2'd2
    } estado_t;

    typedef logic [3:0] digito_bcd_t;

    localparam logic [6:0] SEG_0      = 7'b1000000;
    localparam logic [6:0] SEG_1      = 7'b1111001;
    localparam logic [6:0] SEG_2      = 7'b0100100;
    localparam logic [6:0] SEG_3      = 7'b0110000;
    localparam logic [6:0] SEG_4      = 7'b0011001;
    localparam logic [6:0] SEG_5      = 7'b0010010;
    localparam logic [6:0] SEG_6      = 7'b0000010;
    localparam logic [6:0] SEG_7      = 7'b1111000;
    localparam logic [6:0] SEG_8      = 7'b0000000;
    localparam logic [6:0] SEG_9      = 7'b0010000;
    localparam logic [6:0] SEG_MENOS  = 7'b0111111;
    localparam logic [6:0] SEG_BLANCO = 7'b1111111;

    // Add 3 to every BCD digit that is 5 or more, ahead of the left shift.
    function automatic logic [11:0] ajustar_bcd(input logic [11:0] bcd);
        logic [11:0] resultado;
        resultado[3:0]   = (bcd[3:0]   >= 4'd5) ? bcd[3:0]   + 4'd3 : bcd[3:0];
        resultado[7:4]   = (bcd[7:4]   >= 4'd5) ? bcd[7:4]   + 4'd3 : bcd[7:4];
        resultado[11:8]  = (bcd[11:8]  >= 4'd5) ? bcd[11:8]  + 4'd3 : bcd[11:8];
        return resultado;
    endfunction

endpackage

// File: rtl/subsistema_despliegue_decodificador.sv
// Combinational BCD digit to active-low 7-segment decoder with minus/blank overrides.
import paquete_despliegue::*;

module decodificador_siete_segmentos (
    input  digito_bcd_t digito,
    input  logic        blanco,
    input  logic        menos,
    output logic [6:0]  segmentos
);

    // Minus wins over blank; codes above 9 cannot occur but show blank if they do.
    always_comb begin
        segmentos = SEG_BLANCO;
        if (menos) begin
            segmentos = SEG_MENOS;
        end else if (!blanco) begin
            case (digito)
                4'd0:    segmentos = SEG_0;
                4'd1:    segmentos = SEG_1;
                4'd2:    segmentos = SEG_2;
                4'd3:    segmentos = SEG_3;
                4'd4:    segmentos = SEG_4;
                4'd5:    segmentos = SEG_5;
                4'd6:    segmentos = SEG_6;
                4'd7:    segmentos = SEG_7;
                4'd8:    segmentos = SEG_8;
                4'd9:    segmentos = SEG_9;
                default: segmentos = SEG_BLANCO;
            endcase
        end
    end

endmodule

// File: rtl/subsistema_despliegue.sv
// Product display: handshake capture, sequential double-dabble, 4-digit multiplexed display.
// Define SUBSISTEMA_DESPLIEGUE_SIGNO_EN to treat producto as two's complement with a minus digit.
import paquete_despliegue::*;

module subsistema_despliegue #(
    parameter int DIV_REFRESCO = 50000
) (
    input  logic       reloj,
    input  logic       reinicio,
    input  logic [7:0] producto,
    input  logic       banderaProducto,
    output logic       listoDespliegue,
    output logic       banderaDespliegue,
    output logic [6:0] segmentos,
    output logic [3:0] anodos,
    output estado_t    estadoDepuracion
);

    localparam int ANCHO_CUENTA = (DIV_REFRESCO > 2) ? $clog2(DIV_REFRESCO) : 1;
    localparam logic [ANCHO_CUENTA-1:0] CUENTA_MAX = ANCHO_CUENTA'(DIV_REFRESCO - 1);

    estado_t                 r_estado;
    logic                    r_listo;
    logic                    r_bandera;
    logic [7:0]              r_binario;
    logic [11:0]             r_bcd;
    logic [2:0]              r_iteracion;
    logic                    r_negativo_pend;
    digito_bcd_t             r_unidades;
    digito_bcd_t             r_decenas;
    digito_bcd_t             r_centenas;
    logic                    r_negativo;
    logic                    r_display_valido;
    logic [ANCHO_CUENTA-1:0] r_cuenta;
    logic [1:0]              r_indice;
    logic [3:0]              r_anodos;
    logic [6:0]              r_segmentos;

    logic        w_transferencia;
    logic        w_negativo;
    logic [7:0]  w_magnitud;
    logic [19:0] w_desplazado;
    logic [11:0] w_bcd_siguiente;
    logic [7:0]  w_binario_siguiente;
    digito_bcd_t w_digito;
    logic        w_blanco;
    logic        w_menos;
    logic [6:0]  w_segmentos;

    // Handshake: a product is taken on any rising edge where banderaProducto and
    // listoDespliegue are both 1; listo is registered and low only while converting.
    assign w_transferencia = banderaProducto && r_listo;

`ifdef SUBSISTEMA_DESPLIEGUE_SIGNO_EN
    assign w_negativo = producto[7];
    assign w_magnitud = producto[7] ? (~producto + 8'd1) : producto;
`else
    assign w_negativo = 1'b0;
    assign w_magnitud = producto;
`endif

    always_comb begin
        w_desplazado        = {ajustar_bcd(r_bcd), r_binario} << 1;
        w_bcd_siguiente     = w_desplazado[19:8];
        w_binario_siguiente = w_desplazado[7:0];
    end

    always_ff @(posedge reloj) begin
        if (reinicio) begin
            r_estado         <= ESPERA;
            r_listo          <= 1'b1;
            r_bandera        <= 1'b0;
            r_binario        <= 8'd0;
            r_bcd            <= 12'd0;
            r_iteracion      <= 3'd0;
            r_negativo_pend  <= 1'b0;
            r_unidades       <= 4'd0;
            r_decenas        <= 4'd0;
            r_centenas       <= 4'd0;
            r_negativo       <= 1'b0;
            r_display_valido <= 1'b0;
        end else begin
            r_bandera <= 1'b0;
            case (r_estado)
                ESPERA, MUESTRA: begin
                    r_listo <= 1'b1;
                    if (w_transferencia) begin
                        r_estado        <= CONVIERTE;
                        r_listo         <= 1'b0;
                        r_binario       <= w_magnitud;
                        r_bcd           <= 12'd0;
                        r_iteracion     <= 3'd0;
                        r_negativo_pend <= w_negativo;
                    end
                end
                CONVIERTE: begin
                    r_binario   <= w_binario_siguiente;
                    r_bcd       <= w_bcd_siguiente;
                    r_iteracion <= r_iteracion + 3'd1;
                    // The last shift lands straight in the display digits so they change together.
                    if (r_iteracion == 3'd7) begin
                        r_estado         <= MUESTRA;
                        r_listo          <= 1'b1;
                        r_bandera        <= 1'b1;
                        r_unidades       <= w_bcd_siguiente[3:0];
                        r_decenas        <= w_bcd_siguiente[7:4];
                        r_centenas       <= w_bcd_siguiente[11:8];
                        r_negativo       <= r_negativo_pend;
                        r_display_valido <= 1'b1;
                    end
                end
                default: begin
                    r_estado <= ESPERA;
                    r_listo  <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        w_digito = 4'd0;
        w_blanco = 1'b1;
        w_menos  = 1'b0;
        case (r_indice)
            2'd0: begin
                w_digito = r_unidades;
                w_blanco = 1'b0;
            end
            2'd1: begin
                w_digito = r_decenas;
                w_blanco = (r_centenas == 4'd0) && (r_decenas == 4'd0);
            end
            2'd2: begin
                w_digito = r_centenas;
                w_blanco = (r_centenas == 4'd0);
            end
            default: begin
                w_blanco = !r_negativo;
                w_menos  = r_negativo;
            end
        endcase
    end

    decodificador_siete_segmentos u_decodificador (
        .digito    (w_digito),
        .blanco    (w_blanco),
        .menos     (w_menos),
        .segmentos (w_segmentos)
    );

    always_ff @(posedge reloj) begin
        if (reinicio) begin
            r_cuenta    <= '0;
            r_indice    <= 2'd0;
            r_anodos    <= 4'b1111;
            r_segmentos <= SEG_BLANCO;
        end else begin
            if (r_cuenta == CUENTA_MAX) begin
                r_cuenta <= '0;
                r_indice <= r_indice + 2'd1;
            end else begin
                r_cuenta <= r_cuenta + 1'b1;
            end
            if (r_display_valido) begin
                r_anodos    <= ~(4'b0001 << r_indice);
                r_segmentos <= w_segmentos;
            end else begin
                r_anodos    <= 4'b1111;
                r_segmentos <= SEG_BLANCO;
            end
        end
    end

    assign listoDespliegue   = r_listo;
    assign banderaDespliegue = r_bandera;
    assign segmentos         = r_segmentos;
    assign anodos            = r_anodos;
    assign estadoDepuracion  = r_estado;

endmodule
